// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone classic arbiter with bus-timeout watchdog
//
// Shares one Wishbone slave bus between master 0 (SPI bridge) and master 1
// (local sequencer). Arbitration is round-robin per bus cycle: the owner
// keeps the bus while its CYC is high. A watchdog aborts a strobe that the
// slave leaves unanswered for TIMEOUT cycles (TIMEOUT = 0 disables it).
//
// Ports:
//   i_clk, i_resetn        clock, asynchronous active-low reset
//   m0_wb_*_i / m0_wb_*_o  master 0 request in, data/ack/err out
//   m1_wb_*_i / m1_wb_*_o  master 1 request in, data/ack/err out
//   s_wb_*_o / s_wb_*_i    slave-side request out, response in
//   o_grant                one-hot owner (bit0 = m0, bit1 = m1), 00 when idle
//   o_timeout              one-cycle pulse when the watchdog aborts a cycle

module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_resetn,

  input  logic [AW-1:0]   m0_wb_adr_i,
  input  logic [DW-1:0]   m0_wb_dat_i,
  input  logic [DW/8-1:0] m0_wb_sel_i,
  input  logic            m0_wb_we_i,
  input  logic            m0_wb_stb_i,
  input  logic            m0_wb_cyc_i,
  output logic [DW-1:0]   m0_wb_dat_o,
  output logic            m0_wb_ack_o,
  output logic            m0_wb_err_o,

  input  logic [AW-1:0]   m1_wb_adr_i,
  input  logic [DW-1:0]   m1_wb_dat_i,
  input  logic [DW/8-1:0] m1_wb_sel_i,
  input  logic            m1_wb_we_i,
  input  logic            m1_wb_stb_i,
  input  logic            m1_wb_cyc_i,
  output logic [DW-1:0]   m1_wb_dat_o,
  output logic            m1_wb_ack_o,
  output logic            m1_wb_err_o,

  output logic [AW-1:0]   s_wb_adr_o,
  output logic [DW-1:0]   s_wb_dat_o,
  output logic [DW/8-1:0] s_wb_sel_o,
  output logic            s_wb_we_o,
  output logic            s_wb_stb_o,
  output logic            s_wb_cyc_o,
  input  logic [DW-1:0]   s_wb_dat_i,
  input  logic            s_wb_ack_i,
  input  logic            s_wb_err_i,

  output logic [1:0]      o_grant,
  output logic            o_timeout
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;       // 1: m1 was served last
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  // Hold the last muxed request so idle/abort cycles show stable values.
  logic [AW-1:0]     adr_q;
  logic [DW-1:0]     dat_q;
  logic [DW/8-1:0]   sel_q;
  logic              we_q;

  logic              own;
  logic              owner_cyc, owner_stb, other_cyc;
  logic [AW-1:0]     req_adr;
  logic [DW-1:0]     req_dat;
  logic [DW/8-1:0]   req_sel;
  logic              req_we;
  logic              resp;
  logic              expire;

  assign own       = (state_q == S_OWN);
  assign owner_cyc = grant_q[1] ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign owner_stb = grant_q[1] ? m1_wb_stb_i : m0_wb_stb_i;
  assign other_cyc = grant_q[1] ? m0_wb_cyc_i : m1_wb_cyc_i;

  assign req_adr = grant_q[1] ? m1_wb_adr_i : m0_wb_adr_i;
  assign req_dat = grant_q[1] ? m1_wb_dat_i : m0_wb_dat_i;
  assign req_sel = grant_q[1] ? m1_wb_sel_i : m0_wb_sel_i;
  assign req_we  = grant_q[1] ? m1_wb_we_i  : m0_wb_we_i;

  // Request path: combinational from the grant register.
  assign s_wb_adr_o = own ? req_adr : adr_q;
  assign s_wb_dat_o = own ? req_dat : dat_q;
  assign s_wb_sel_o = own ? req_sel : sel_q;
  assign s_wb_we_o  = own ? req_we  : we_q;
  assign s_wb_cyc_o = own & owner_cyc;
  assign s_wb_stb_o = own & owner_stb;

  // Response path: zero latency, owner only, dropped outside OWN.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign m0_wb_ack_o = own & grant_q[0] & s_wb_ack_i;
  assign m1_wb_ack_o = own & grant_q[1] & s_wb_ack_i;
  // timeout_q is only set during the first ABORT cycle, where grant_q still
  // names the aborted owner.
  assign m0_wb_err_o = (own & grant_q[0] & s_wb_err_i) | (timeout_q & grant_q[0]);
  assign m1_wb_err_o = (own & grant_q[1] & s_wb_err_i) | (timeout_q & grant_q[1]);

  assign o_grant   = grant_q;
  assign o_timeout = timeout_q;

  assign resp   = s_wb_ack_i | s_wb_err_i;
  assign expire = (TIMEOUT != 0) && s_wb_stb_o && !resp && (cnt_q == LIMIT);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // On a tie the master not served last wins.
        if (m0_wb_cyc_i && (!m1_wb_cyc_i || last_q)) begin
          state_d = S_OWN;
          grant_d = 2'b01;
          last_d  = 1'b0;
        end else if (m1_wb_cyc_i) begin
          state_d = S_OWN;
          grant_d = 2'b10;
          last_d  = 1'b1;
        end
      end
      S_OWN: begin
        // A CYC drop takes priority over a simultaneous watchdog expiry.
        if (!owner_cyc) begin
          if (other_cyc) begin
            grant_d = {grant_q[0], grant_q[1]};
            last_d  = grant_q[0];
          end else begin
            state_d = S_IDLE;
            grant_d = 2'b00;
          end
        end else if (expire) begin
          state_d   = S_ABORT;
          timeout_d = 1'b1;
        end else if (s_wb_stb_o && !resp) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ABORT: begin
        if (!owner_cyc) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (own) begin
        adr_q <= req_adr;
        dat_q <= req_dat;
        sel_q <= req_sel;
        we_q  <= req_we;
      end
    end
  end

endmodule
